// File: rtl/rf_pkg.sv
// Shared definitions for the scrubbable register file: default geometry,
// scrub FSM states and the depth helper.
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_DEPTH  = 1 << RF_ADDR_W;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard: one bit per register, set by a
// reservation, cleared by a write, wiped as a whole when a scrub starts.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_all,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic              pend0,
    output logic              pend1
);

    localparam int DEPTH = rf_depth(ADDR_W);

    logic [DEPTH-1:0] pend_r;
    logic [DEPTH-1:0] pend_nxt_s;

    // Next pending vector; a new producer supersedes a retiring write to the same register
    always_comb begin
        pend_nxt_s = pend_r;
        for (int i = 0; i < DEPTH; i++) begin
            if ((ZERO_REG != 0) && (i == 0)) begin
                pend_nxt_s[i] = 1'b0;
            end else if (set_en && (set_addr == ADDR_W'(i))) begin
                pend_nxt_s[i] = 1'b1;
            end else if (clr_en && (clr_addr == ADDR_W'(i))) begin
                pend_nxt_s[i] = 1'b0;
            end else begin
                pend_nxt_s[i] = pend_r[i];
            end
        end
    end

    // Pending vector register; scrub start wipes every bit
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_r <= '0;
        end else if (clr_all) begin
            pend_r <= '0;
        end else begin
            pend_r <= pend_nxt_s;
        end
    end

    assign pend0 = pend_r[raddr0];
    assign pend1 = pend_r[raddr1];

endmodule

// File: rtl/reg_file_scrub_sb.sv
// Two-read/one-write register file with optional write bypass, a pending-write
// scoreboard and a sequential scrub engine that zeroes one register per cycle.
module reg_file_scrub_sb
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              busy,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [DATA_W-1:0] rdata0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              pend0,
    output logic              pend1
);

    localparam int                DEPTH    = rf_depth(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_e         state_r;
    rf_state_e         state_nxt_s;
    logic [ADDR_W-1:0] idx_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic idle_s;
    logic wr_acc_s;
    logic rsv_acc_s;
    logic scrub_start_s;
    logic sb_pend0_s;
    logic sb_pend1_s;

    assign idle_s        = (state_r == RF_IDLE);
    assign wr_acc_s      = we && idle_s && !((ZERO_REG != 0) && (waddr == '0));
    assign rsv_acc_s     = rsv_en && idle_s && !((ZERO_REG != 0) && (rsv_addr == '0));
    assign scrub_start_s = idle_s && clr_req;
    // busy is the registered state bit itself, so clr_req never reaches it combinationally
    assign busy          = (state_r == RF_CLEAR);

    // Scrub FSM next state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RF_IDLE: begin
                if (clr_req) begin
                    state_nxt_s = RF_CLEAR;
                end else begin
                    state_nxt_s = RF_IDLE;
                end
            end
            RF_CLEAR: begin
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = RF_IDLE;
                end else begin
                    state_nxt_s = RF_CLEAR;
                end
            end
            default: state_nxt_s = RF_IDLE;
        endcase
    end

    // Scrub state and index; the index wraps to 0 after the last register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= RF_IDLE;
            idx_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (scrub_start_s) begin
                idx_r <= '0;
            end else if (busy) begin
                idx_r <= idx_r + ADDR_W'(1);
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // Data array: scrub owns the write port while busy
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (busy) begin
            mem_r[idx_r] <= '0;
        end else if (wr_acc_s) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port 0 with zero-register and same-cycle write forwarding
    always_comb begin
        if ((ZERO_REG != 0) && (raddr0 == '0)) begin
            rdata0 = '0;
        end else if ((BYPASS != 0) && wr_acc_s && (waddr == raddr0)) begin
            rdata0 = wdata;
        end else begin
            rdata0 = mem_r[raddr0];
        end
    end

    // Read port 1 with zero-register and same-cycle write forwarding
    always_comb begin
        if ((ZERO_REG != 0) && (raddr1 == '0)) begin
            rdata1 = '0;
        end else if ((BYPASS != 0) && wr_acc_s && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = mem_r[raddr1];
        end
    end

    rf_scoreboard #(
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .clr_all (scrub_start_s),
        .set_en  (rsv_acc_s),
        .set_addr(rsv_addr),
        .clr_en  (wr_acc_s),
        .clr_addr(waddr),
        .raddr0  (raddr0),
        .raddr1  (raddr1),
        .pend0   (sb_pend0_s),
        .pend1   (sb_pend1_s)
    );

    assign pend0 = idle_s && sb_pend0_s;
    assign pend1 = idle_s && sb_pend1_s;

endmodule

// File: tb/tb_reg_file_scrub_sb.sv
// Scoreboard bench: three configurations share one stimulus stream and are
// checked every cycle against an array-level reference model.
module tb_reg_file_scrub_sb;

    localparam int          CFG_AW   [3] = '{5, 5, 3};
    localparam int          CFG_ZERO [3] = '{1, 1, 0};
    localparam int          CFG_BYP  [3] = '{1, 0, 1};
    localparam logic [31:0] CFG_MASK [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, clr_req, we, rsv_en;
    logic [4:0]  waddr, raddr0, raddr1, rsv_addr;
    logic [31:0] wdata;

    logic        busy_a, busy_b, busy_c;
    logic [31:0] rdata0_a, rdata1_a, rdata0_b, rdata1_b;
    logic [15:0] rdata0_c, rdata1_c;
    logic        pend0_a, pend1_a, pend0_b, pend1_b, pend0_c, pend1_c;

    reg_file_scrub_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy_a),
        .we(we), .waddr(waddr), .wdata(wdata),
        .raddr0(raddr0), .rdata0(rdata0_a), .raddr1(raddr1), .rdata1(rdata1_a),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend0(pend0_a), .pend1(pend1_a));

    reg_file_scrub_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy_b),
        .we(we), .waddr(waddr), .wdata(wdata),
        .raddr0(raddr0), .rdata0(rdata0_b), .raddr1(raddr1), .rdata1(rdata1_b),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend0(pend0_b), .pend1(pend1_b));

    reg_file_scrub_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut_c (
        .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy_c),
        .we(we), .waddr(waddr[2:0]), .wdata(wdata[15:0]),
        .raddr0(raddr0[2:0]), .rdata0(rdata0_c), .raddr1(raddr1[2:0]), .rdata1(rdata1_c),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr[2:0]), .pend0(pend0_c), .pend1(pend1_c));

    typedef struct {
        int          d;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t  exp_q[$];
    string seln[5] = '{"rdata0", "rdata1", "pend0", "pend1", "busy"};
    int    n_tests = 0;
    int    n_fail  = 0;

    // Reference model: plain register arrays plus a remaining-scrub-cycles counter
    logic [31:0] m_mem  [3][32];
    bit          m_pend [3][32];
    int          m_busy [3];
    int          m_pos  [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] actual(input int d, input int sel);
        logic [31:0] v [5];
        case (d)
            0: v = '{rdata0_a, rdata1_a, {31'd0, pend0_a}, {31'd0, pend1_a}, {31'd0, busy_a}};
            1: v = '{rdata0_b, rdata1_b, {31'd0, pend0_b}, {31'd0, pend1_b}, {31'd0, busy_b}};
            default: v = '{{16'd0, rdata0_c}, {16'd0, rdata1_c}, {31'd0, pend0_c},
                           {31'd0, pend1_c}, {31'd0, busy_c}};
        endcase
        return v[sel];
    endfunction

    function automatic logic [31:0] model_out(input int d, input int sel);
        int depth, wa, a;
        bit idle, wr_ok;
        depth = 1 << CFG_AW[d];
        wa    = int'(waddr) % depth;
        idle  = (m_busy[d] == 0);
        wr_ok = we && idle && !((CFG_ZERO[d] != 0) && wa == 0);
        a     = ((sel == 1) || (sel == 3)) ? int'(raddr1) % depth : int'(raddr0) % depth;
        case (sel)
            0, 1: begin
                if ((CFG_ZERO[d] != 0) && a == 0) return 32'd0;
                if ((CFG_BYP[d] != 0) && wr_ok && wa == a) return wdata & CFG_MASK[d];
                return m_mem[d][a];
            end
            2, 3:    return idle ? {31'd0, m_pend[d][a]} : 32'd0;
            default: return idle ? 32'd0 : 32'd1;
        endcase
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 3; d++) begin
            int depth, wa, ra;
            bit idle, wr_ok, rs_ok;
            depth = 1 << CFG_AW[d];
            wa    = int'(waddr) % depth;
            ra    = int'(rsv_addr) % depth;
            idle  = (m_busy[d] == 0);
            wr_ok = we && idle && !((CFG_ZERO[d] != 0) && wa == 0);
            rs_ok = rsv_en && !((CFG_ZERO[d] != 0) && ra == 0);
            if (reset) begin
                for (int i = 0; i < 32; i++) begin
                    m_mem[d][i]  = 32'd0;
                    m_pend[d][i] = 1'b0;
                end
                m_busy[d] = 0;
                m_pos[d]  = 0;
            end else if (idle) begin
                if (wr_ok) m_mem[d][wa] = wdata & CFG_MASK[d];
                if (clr_req) begin
                    for (int i = 0; i < 32; i++) m_pend[d][i] = 1'b0;
                    m_busy[d] = depth;
                    m_pos[d]  = 0;
                end else begin
                    if (wr_ok) m_pend[d][wa] = 1'b0;
                    if (rs_ok) m_pend[d][ra] = 1'b1;
                end
            end else begin
                m_mem[d][m_pos[d]] = 32'd0;
                m_pos[d]++;
                m_busy[d]--;
            end
        end
    endtask

    task automatic expect_const(input int d, input int sel, input logic [31:0] v, input string name);
        exp_t e;
        e.d = d; e.sel = sel; e.exp = v; e.name = name;
        exp_q.push_back(e);
    endtask

    // One cycle: queue model expectations for the current inputs, then advance
    task automatic step();
        for (int d = 0; d < 3; d++)
            for (int s = 0; s < 5; s++)
                expect_const(d, s, model_out(d, s), $sformatf("dut%0d_%s", d, seln[s]));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiet();
        we = 1'b0; rsv_en = 1'b0; clr_req = 1'b0;
    endtask

    task automatic scrub_run(input bit extras, output int na, output int nc);
        na = 0; nc = 0;
        clr_req = 1'b1;
        step();
        for (int c = 0; c < 40; c++) begin
            quiet();
            raddr1 = 5'd31;
            if (busy_a) na++;
            if (busy_c) nc++;
            if (extras && c == 3) clr_req = 1'b1;
            if (extras && c == 5) begin we = 1'b1; waddr = 5'd9; wdata = 32'hBAD0_BAD0; end
            if (extras && c == 10) expect_const(0, 1, 32'd93, "scrub_mid_rd31");
            step();
        end
    endtask

    // Monitor: compare every queued expectation against the settled outputs
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, actual(e.d, e.sel), e.exp);
        end
    end

    initial begin
        int na, nc;
        reset = 1'b1; clr_req = 1'b0; we = 1'b0; rsv_en = 1'b0;
        waddr = 5'd0; wdata = 32'd0; raddr0 = 5'd0; raddr1 = 5'd0; rsv_addr = 5'd0;
        @(posedge clk);
        model_edge();
        #1;
        step();
        reset = 1'b0;

        // Write forwarding vs. next-cycle visibility
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; raddr0 = 5'd5;
        expect_const(0, 0, 32'hDEAD_BEEF, "bypass_same_cycle");
        expect_const(1, 0, 32'd0, "nobypass_same_cycle");
        step();
        quiet();
        expect_const(0, 0, 32'hDEAD_BEEF, "bypass_after_edge");
        expect_const(1, 0, 32'hDEAD_BEEF, "nobypass_after_edge");
        step();

        // Register 0 handling
        we = 1'b1; waddr = 5'd0; wdata = 32'h1234_5678;
        step();
        quiet(); raddr0 = 5'd0; raddr1 = 5'd0; rsv_en = 1'b1; rsv_addr = 5'd0;
        expect_const(0, 0, 32'd0, "zero_rd0");
        expect_const(0, 1, 32'd0, "zero_rd1");
        expect_const(2, 0, 32'h0000_5678, "small_rd_addr0");
        step();
        quiet();
        expect_const(0, 2, 32'd0, "zero_never_pending");
        expect_const(2, 2, 32'd1, "small_pend_addr0");
        step();

        // Scoreboard set/clear priority on register 7
        rsv_en = 1'b1; rsv_addr = 5'd7; raddr1 = 5'd7;
        step();
        quiet(); we = 1'b1; waddr = 5'd7; wdata = 32'h0000_A5A5;
        expect_const(0, 3, 32'd1, "rsv7_pending");
        step();
        quiet(); rsv_en = 1'b1; rsv_addr = 5'd7; we = 1'b1; waddr = 5'd7; wdata = 32'h0000_0077;
        expect_const(0, 3, 32'd0, "write7_cleared");
        step();
        quiet(); raddr0 = 5'd7;
        expect_const(0, 3, 32'd1, "set_beats_clear");
        expect_const(0, 0, 32'h0000_0077, "set_clear_data");
        step();

        // Full scrub
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = 32'(i * 3);
            rsv_en = (i % 4 == 0); rsv_addr = 5'(i + 1);
            step();
        end
        quiet();
        scrub_run(1'b1, na, nc);
        check("busy_len_32", 32'(na), 32'd32);
        check("busy_len_8", 32'(nc), 32'd8);
        for (int i = 0; i < 32; i++) begin
            raddr0 = 5'(i); raddr1 = 5'(31 - i);
            expect_const(0, 0, 32'd0, "post_scrub_rd");
            expect_const(0, 2, 32'd0, "post_scrub_pend");
            step();
        end

        // Reset during a scrub, then a clean restart
        we = 1'b1; waddr = 5'd31; wdata = 32'h0000_0031;
        step();
        quiet(); clr_req = 1'b1;
        step();
        quiet();
        repeat (12) step();
        reset = 1'b1; raddr0 = 5'd31;
        step();
        reset = 1'b0;
        expect_const(0, 4, 32'd0, "reset_mid_scrub_busy");
        expect_const(0, 0, 32'd0, "reset_mid_scrub_rd31");
        step();
        scrub_run(1'b0, na, nc);
        check("restart_busy_len_32", 32'(na), 32'd32);

        // Small configuration without a zero register
        we = 1'b1; waddr = 5'd0; wdata = 32'h0000_BEEF;
        step();
        quiet(); raddr0 = 5'd0;
        expect_const(2, 0, 32'h0000_BEEF, "small_write_addr0");
        step();

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            reset    = ($urandom_range(0, 299) == 0);
            clr_req  = ($urandom_range(0, 79) == 0);
            we       = $urandom_range(0, 2) != 0;
            waddr    = 5'($urandom);
            wdata    = $urandom;
            rsv_en   = $urandom_range(0, 1) == 1;
            rsv_addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            raddr0   = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
            raddr1   = ($urandom_range(0, 2) == 0) ? rsv_addr : 5'($urandom);
            step();
        end
        reset = 1'b0; quiet();
        step();
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_scrub_sb.md
Name: reg_file_scrub_sb

Overview:
- Parametrised successor of the 32x32 MIPS register file: configurable data width and depth, two combinational read ports, one write port and optional write-to-read bypass.
- Adds a per-register pending-write scoreboard for the multicycle and pipelined datapaths.
- Adds a sequential bulk-clear (scrub) engine with a busy handshake.
- Sits between the decode stage (reads and reservations) and the writeback stage (writes).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero (reads 0, writes and reservations ignored).
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- clr_req  in  1  pulse; starts a sequential scrub of all registers.
- busy  out  1  high while the scrub is in progress.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- raddr0  in  ADDR_W  read port 0 address.
- rdata0  out  DATA_W  read port 0 data.
- raddr1  in  ADDR_W  read port 1 address.
- rdata1  out  DATA_W  read port 1 data.
- rsv_en  in  1  marks rsv_addr as having an outstanding producer.
- rsv_addr  in  ADDR_W  register being reserved.
- pend0  out  1  pending bit of raddr0.
- pend1  out  1  pending bit of raddr1.

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-high.
  - On a reset edge: all registers = 0, all pending bits = 0, FSM = IDLE, scrub index = 0, busy = 0.
  - Reset takes priority over every other input, including mid-scrub; the scrub aborts and the FSM returns to IDLE.
- Reads: combinational, zero latency.
  - rdataN = reg[raddrN].
  - If ZERO_REG and raddrN == 0: rdataN = 0.
  - If BYPASS, state IDLE, we = 1, waddr == raddrN and the write is not ignored: rdataN = wdata.
  - BYPASS = 0: the written value is visible on the cycle after the edge.
- Writes: reg[waddr] <= wdata on the rising edge when we = 1 and state = IDLE.
  - Ignored if ZERO_REG and waddr == 0.
  - Ignored while busy; there is no queueing, and the producer must hold off.
- Scoreboard: one pending bit per register.
  - rsv_en sets pend[rsv_addr] at the next edge.
  - An accepted write clears pend[waddr].
  - Same address and same cycle for rsv_en and an accepted write: set wins (the new producer supersedes).
  - Different addresses: both updates apply.
  - Register 0 is never pending when ZERO_REG = 1.
  - pendN = pend[raddrN]; combinational, no bypass of the same-cycle set/clear.
  - rsv_en is ignored while busy.
- Scrub FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clr_req = 1 at an edge. At that edge: all pending bits cleared, index <= 0, busy goes high the following cycle. A write in that same cycle is still accepted.
  - CLEAR: each edge writes reg[index] <= 0 and increments index.
  - When index == DEPTH-1 is written: FSM -> IDLE, busy drops.
  - busy is high for exactly DEPTH cycles.
  - Index arithmetic is ADDR_W bits; the last increment wraps to 0, which is harmless.
  - clr_req while in CLEAR is ignored (no restart).
  - Reads during CLEAR return the live array, so partially scrubbed values are visible. pendN reads 0 during CLEAR.
- busy is a registered output (the FSM state bit); it has no combinational path from clr_req.

Decomposition:
- Shared package rf_pkg holds:
  - the state enum (RF_IDLE, RF_CLEAR);
  - localparam helpers DEPTH = 1 << ADDR_W;
  - the default DATA_W and ADDR_W constants, shared with the datapath top.
- Natural sub-module: rf_scoreboard. It holds the DEPTH-bit pending vector, the set/clear priority, the global clear and two read taps. The data array, bypass muxing and scrub FSM stay in the top module.

Test Plan:
- Write and bypass, BYPASS = 1: we = 1, waddr = 5, wdata = 0xDEADBEEF, raddr0 = 5 in the same cycle -> rdata0 = 0xDEADBEEF combinationally that cycle and also after the edge. With BYPASS = 0 -> rdata0 shows the old value (0) that cycle and 0xDEADBEEF after the edge.
- Zero register: write 0x12345678 to address 0, then read address 0 on both ports -> 0. rsv_en with rsv_addr = 0 -> pend0 stays 0.
- Scoreboard priority:
  - rsv_en on 7 -> pend1 = 1 with raddr1 = 7.
  - Write to 7 -> pend1 = 0.
  - rsv_en on 7 and a write to 7 in the same cycle -> pend1 = 1 after the edge and reg[7] holds the written data.
- Scrub, DEPTH = 32:
  - Fill regs 1..31 with i*3.
  - Pulse clr_req -> busy high for exactly 32 cycles.
  - Reading 31 at cycle 10 of the scrub returns 93.
  - After busy drops, all regs read 0, all pending bits 0, and a write issued during busy is absent.
- Reset mid-scrub: assert reset at scrub cycle 12 -> next cycle busy = 0, all regs 0. A clr_req on the next cycle restarts with a full 32-cycle busy.
- Parameter sweep: DATA_W = 16, ADDR_W = 3, ZERO_REG = 0.
  - Write 0xBEEF to address 0 -> reads back 0xBEEF.
  - Scrub takes 8 cycles.
  - Reserving 0 sets pend0 = 1 with raddr0 = 0.
